// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
// The FSM encoding is fixed so that the state can be probed in the field.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_BUSY_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // An index into a single-entry vector still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester above the
// pointer, wrapping modulo N, as both a one-hot vector and an index.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int cand;

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = |req_i;
    cand     = 0;
    // Scan from the farthest offset down so the nearest hit overwrites last.
    for (int off = N; off >= 1; off--) begin
      cand = (int'(ptr_i) + off) % N;
      if (req_i[cand]) begin
        onehot_o = N'(1) << cand;
        idx_o    = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit engine between NUM_REQ byte producers, granting
// round-robin with bounded bursts and a watchdog on the engine's busy flag.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      active,
  output logic                      timeout
);

  localparam int             IW         = idx_width(NUM_REQ);
  localparam logic [IW-1:0]  PTR_INIT   = IW'(NUM_REQ - 1);
  localparam logic [7:0]     BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0]     TIMER_LAST = 8'(BUSY_TIMEOUT - 1);

  arb_state_e          state_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       gidx_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [7:0]          burst_q;
  logic [7:0]          timer_q;
  logic                tx_start_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic                active_q;
  logic                timeout_q;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [BYTE_W-1:0]   req_byte [NUM_REQ];
  logic                gnt_valid;
  logic [BYTE_W-1:0]   gnt_byte;

  uart_tx_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[BYTE_W*i +: BYTE_W];
    end
  end

  assign gnt_valid = req_valid[gidx_q];
  assign gnt_byte  = req_byte[gidx_q];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; tx_start/timeout default low each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_INIT;
      gidx_q     <= '0;
      grant_q    <= '0;
      burst_q    <= '0;
      timer_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      active_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Holding off while busy also covers an engine left running by reset.
          if (!tx_busy && pick_any) begin
            grant_q  <= pick_onehot;
            gidx_q   <= pick_idx;
            ptr_q    <= pick_idx;
            burst_q  <= '0;
            active_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          tx_data_q  <= gnt_byte;
          tx_start_q <= 1'b1;
          timer_q    <= '0;
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TIMER_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= WAIT_DONE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (gnt_valid && (burst_q < BURST_LAST)) begin
              burst_q <= burst_q + 8'd1;
              state_q <= ISSUE;
            end else begin
              grant_q  <= '0;
              active_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ISSUE) ? grant_q : '0;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign active    = active_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmit engine between NUM_REQ byte producers. Each producer offers bytes on a valid/ready interface. The arbiter grants one producer at a time, forwards its bytes as single-cycle start pulses to the transmit engine, and tracks the engine's busy flag. It sits between the protocol/status blocks and the single shared TX line, the transmit counterpart of the existing receiver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, maximum bytes sent per grant before forced re-arbitration (1..255)
BUSY_TIMEOUT, 255, cycles to wait for tx_busy to rise after tx_start before giving up (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
req_ready  out  NUM_REQ  per-requester accept strobe, one-hot or zero
tx_start  out  1  one-cycle start pulse to the transmit engine
tx_data  out  8  byte to transmit, stable from tx_start until tx_busy falls
tx_busy  in  1  engine busy; rises within BUSY_TIMEOUT cycles of tx_start, falls when the stop bit is done
grant  out  NUM_REQ  one-hot current owner, zero when idle
active  out  1  high whenever grant is non-zero
timeout  out  1  one-cycle pulse when tx_busy failed to rise in time

Behaviour:
- Reset (async assert on reset=0):
  - Outputs: tx_start=0, tx_data=0, grant=0, active=0, timeout=0, req_ready=0.
  - Internals: state=IDLE, last-grant pointer=NUM_REQ-1 (requester 0 wins first), burst count=0, timer=0.
- Reset mid-transfer: the block aborts immediately and the engine is not signalled. After release, IDLE does not arbitrate until tx_busy=0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitrates only if tx_busy=0 and any req_valid=1.
  - Winner is the first valid index searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Next edge: grant=onehot(winner), pointer=winner, burst count=0, state goes to ISSUE.
- ISSUE (exactly 1 cycle):
  - req_ready[grant]=1, combinational from state and grant.
  - Next edge: tx_data<=granted req_data, tx_start<=1, timer<=0, state goes to WAIT_BUSY.
  - If the granted req_valid is 0 here, the requester has violated protocol; the byte is still taken.
- WAIT_BUSY:
  - tx_start is high on the first cycle only and cleared at the next edge.
  - If tx_busy=1, go to WAIT_DONE.
  - Else if timer=BUSY_TIMEOUT-1, pulse timeout for one cycle and go to WAIT_DONE.
  - Else timer+1.
- WAIT_DONE:
  - Stays while tx_busy=1.
  - When tx_busy=0 and granted req_valid=1 and burst count<MAX_BURST-1: burst count+1, go to ISSUE with the same grant (back-to-back bytes).
  - Otherwise: grant=0, go to IDLE. Re-arbitration happens from the updated pointer, so the same requester loses priority.
- Handshake rules:
  - A requester holds req_data stable and req_valid high until it sees req_ready.
  - Dropping valid while granted ends the burst at the next WAIT_DONE exit.
- Throughput: minimum 3 cycles of overhead per byte (ISSUE, one WAIT_BUSY cycle, WAIT_DONE exit) plus the engine busy time.
- Timing of outputs: tx_start and tx_data are registered. grant and active are registered. req_ready is combinational.
- Only the granted requester's req_valid matters after grant. New requests from others wait for IDLE.
- NUM_REQ=1: the pointer always selects 0; bursts are still capped by MAX_BURST.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3 (2 bits)
  - byte width constant 8
  - the default MAX_BURST and BUSY_TIMEOUT values
- One sub-module is natural: rr_pick, combinational. Inputs are request vector and pointer; outputs are one-hot winner, winner index, and any-request.

Test Plan:
- Single requester 2 sends 0xA5 (valid held, engine busy 10 cycles after start) -> grant=0100, req_ready[2] pulses once, tx_start one cycle with tx_data=0xA5, grant=0 after busy falls.
- All four valid continuously, MAX_BURST=2 -> byte order 0,0,1,1,2,2,3,3,0,... and each req_ready count equals 2 per grant.
- Requester 1 drops valid after its first byte while 3 is waiting -> burst ends after 1 byte, next grant=1000.
- tx_busy tied 0, BUSY_TIMEOUT=5 -> timeout pulses 5 cycles after tx_start and the arbiter proceeds to the next byte or IDLE without hang.
- Reset asserted during WAIT_DONE with tx_busy=1 -> outputs 0 immediately; after release no tx_start until tx_busy=0, then requester 0 wins first.
- Requesters 0 and 3 valid with pointer=0 -> requester 3 is granted before requester 0 (wrap search).
